// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver.
// Frame: start(0), D0..D7 LSB-first, optional parity, stop(1).
// Each bit is sampled at edge_cnt = P/2-1, P/2, P/2+1 and resolved by 2-of-3 majority.
// Optional feature: define UART_RX_SYNC_EN to pass rx_in through a 2-flop
// synchronizer (flops reset to 1), adding 2 cycles of latency.
module uart_rx #(
  parameter int PRESCALE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic       par_en,
  input  logic       par_typ,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       par_err,
  output logic       stp_err
);

  localparam int EW = $clog2(PRESCALE);
  localparam logic [EW-1:0] SMP0 = EW'(PRESCALE / 2 - 1);
  localparam logic [EW-1:0] SMP1 = EW'(PRESCALE / 2);
  localparam logic [EW-1:0] SMP2 = EW'(PRESCALE / 2 + 1);
  localparam logic [EW-1:0] LAST = EW'(PRESCALE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e          state_q, state_d;
  logic [EW-1:0]   edge_cnt_q, edge_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [2:0]      samp_q, samp_d;
  logic [7:0]      shift_q, shift_d;
  logic            pen_q, pen_d;
  logic            ptyp_q, ptyp_d;
  logic            perr_q, perr_d;
  logic [7:0]      data_out_q, data_out_d;
  logic            data_valid_q, data_valid_d;
  logic            par_err_q, par_err_d;
  logic            stp_err_q, stp_err_d;

  logic            rx_s;
  logic            last_edge;
  logic            third;
  logic            maj;
  logic [EW-1:0]   edge_cnt_inc;

  // State register; reset aborts any frame in progress.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q, sync_d;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_comb sync_d = {sync_q[0], rx_in};

  // Synchronizer flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= 2'b11;
    else      sync_q <= sync_d;
  end

  assign rx_s = sync_q[1];
`else
  assign rx_s = rx_in;
`endif

  // The third sample is taken on the current edge when edge_cnt = P/2+1, so the
  // STOP decision can be registered on that same edge.
  assign last_edge    = (edge_cnt_q == LAST);
  assign third        = (edge_cnt_q == SMP2) ? rx_s : samp_q[2];
  assign maj          = (samp_q[0] & samp_q[1]) | (samp_q[0] & third) | (samp_q[1] & third);
  assign edge_cnt_inc = last_edge ? '0 : edge_cnt_q + EW'(1);

  // Next-state logic: frame sequencing and glitch rejection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!rx_s) state_d = START;
      START:   if (last_edge) state_d = maj ? IDLE : DATA;
      DATA:    if (last_edge && bit_cnt_q == 3'd7) state_d = pen_q ? PARITY : STOP;
      PARITY:  if (last_edge) state_d = STOP;
      STOP:    if (edge_cnt_q == SMP2) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath logic: counters, sampling, shifting, result registration.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    edge_cnt_d   = edge_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    samp_d       = samp_q;
    shift_d      = shift_q;
    pen_d        = pen_q;
    ptyp_d       = ptyp_q;
    perr_d       = perr_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;

    if (state_q != IDLE) begin
      edge_cnt_d = edge_cnt_inc;
      if (edge_cnt_q == SMP0) samp_d[0] = rx_s;
      if (edge_cnt_q == SMP1) samp_d[1] = rx_s;
      if (edge_cnt_q == SMP2) samp_d[2] = rx_s;
    end

    case (state_q)
      IDLE: begin
        bit_cnt_d  = 3'd0;
        edge_cnt_d = '0;
        if (!rx_s) begin
          // Detect edge is edge 0 of the start bit; frame options are frozen here.
          edge_cnt_d = EW'(1);
          pen_d      = par_en;
          ptyp_d     = par_typ;
          perr_d     = 1'b0;
        end
      end
      DATA: begin
        if (last_edge) begin
          shift_d   = {maj, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      PARITY: begin
        if (last_edge) perr_d = ((^shift_q) ^ maj) != ptyp_q;
      end
      STOP: begin
        if (edge_cnt_q == SMP2) begin
          edge_cnt_d   = '0;
          stp_err_d    = ~maj;
          par_err_d    = perr_q;
          data_valid_d = maj & ~perr_q;
          if (maj && !perr_q) data_out_d = shift_q;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt_q   <= '0;
      bit_cnt_q    <= 3'd0;
      samp_q       <= 3'd0;
      shift_q      <= 8'h00;
      pen_q        <= 1'b0;
      ptyp_q       <= 1'b0;
      perr_q       <= 1'b0;
      data_out_q   <= 8'h00;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      edge_cnt_q   <= edge_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      samp_q       <= samp_d;
      shift_q      <= shift_d;
      pen_q        <= pen_d;
      ptyp_q       <= ptyp_d;
      perr_q       <= perr_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive half of the UART: oversamples the serial line, detects and qualifies start bits, deserializes 8 data bits LSB-first, optionally checks parity, checks the stop bit, and presents the byte as a parallel word with a one-cycle valid pulse. Sits between the RX pin and the host-side byte interface. It is the counterpart of the transmit-side serializer, and uses the same frame format: start(0), D0..D7, optional parity, stop(1).

## Interface
- PRESCALE, 8: clk cycles per bit (oversampling ratio); even, 4..32.
- clk  in  1  oversampling clock, PRESCALE × baud.
- rst  in  1  asynchronous, active-low reset.
- rx_in  in  1  serial line; idle high.
- par_en  in  1  1 = a parity bit follows D7.
- par_typ  in  1  0 = even, 1 = odd parity.
- data_out  out  8  last good received byte.
- data_valid  out  1  one-cycle pulse: data_out updated.
- par_err  out  1  one-cycle pulse: parity mismatch.
- stp_err  out  1  one-cycle pulse: stop bit sampled 0.

## Operation
- The FSM has the states IDLE, START, DATA, PARITY and STOP.
- Bit counter edge_cnt is $clog2(PRESCALE) bits wide and counts 0..PRESCALE-1 within each bit. Bit counter bit_cnt is 3 bits wide.
- Each bit is sampled 3 times, at edge_cnt = P/2-1, P/2 and P/2+1, where P = PRESCALE. The bit value is the 2-of-3 majority.
- IDLE: a 0 on rx_in at an edge moves the FSM to START with edge_cnt←1. That edge counts as edge 0 of the start bit. par_en and par_typ are latched at this edge and hold for the whole frame.
- START, at edge_cnt = P-1: if the majority was 0, the FSM goes to DATA. If the majority was 1 (a glitch), it goes to IDLE with no outputs.
- DATA: the majority bit is shifted in LSB-first. After bit_cnt = 7 completes, the FSM goes to PARITY if the latched par_en = 1, otherwise to STOP.
- PARITY: error = (XOR of D7..D0 ^ sampled parity bit) ≠ latched par_typ. The result is held until STOP.
- STOP, at the edge where edge_cnt = P/2+1, all results are registered together:
  - stp_err = ~majority.
  - par_err = held parity error (0 if parity is disabled).
  - data_valid = ~stp_err & ~par_err.
  - data_out ← shift register, only when data_valid = 1.
  - The FSM then goes to IDLE.
- data_out holds its value between good frames. Bad frames never change it.
- A line held low (break) produces stp_err. IDLE then sees 0 and starts a new frame.

## Timing
- Reset values: data_out = 8'h00, data_valid = 0, par_err = 0, stp_err = 0. The FSM is in IDLE and all counters are 0.
- Latency, measured from the detect edge to the data_valid high edge:
  - 9·P + P/2 + 1 cycles without parity (77 at P = 8).
  - 10·P + P/2 + 1 cycles with parity (85 at P = 8).
- All outputs are registered. Each pulse lasts exactly one cycle. data_valid and the error pulses never overlap.
- The FSM is ready for a new start bit on the cycle after the pulses. The remaining half stop bit is spent in IDLE. Back-to-back frames therefore have no dead time.
- Reset asserted mid-frame: the block goes to IDLE immediately (asynchronously). No pulse is emitted and the partial byte is discarded.
- Changing par_en or par_typ mid-frame has no effect until the next frame.

## Configuration
- UART_RX_SYNC_EN defined: rx_in passes through a 2-flop synchronizer whose flops reset to 1. This adds 2 cycles to every latency figure above (79 and 87 at P = 8).
- UART_RX_SYNC_EN undefined: rx_in feeds the FSM and sampler directly. The source must already be synchronous to clk.

## Test plan
- P = 8, par_en = 0: send 0xA5 with a good stop bit -> data_out = 0xA5, one data_valid pulse 77 cycles after the start edge (79 with sync), no errors.
- par_en = 1, par_typ = 0: send 0x3C with parity bit 0 -> data_valid, data_out = 0x3C. Then send 0x3C with parity bit 1 -> par_err pulse, no data_valid, data_out stays 0x3C.
- par_en = 1, par_typ = 1: send 0x01 with parity bit 0 -> data_valid, data_out = 0x01.
- Send 0x55 with the stop bit driven 0 -> stp_err pulse, no data_valid, data_out unchanged. The next frame, 0x12, is received correctly.
- A 2-cycle low glitch on an idle line -> the FSM returns to IDLE with no pulses. An immediately following frame, 0x7E, is received.
- Assert rst during D4 of a frame -> all outputs are 0 and the FSM is in IDLE. A subsequent frame, 0xC3, gives data_valid with data_out = 0xC3.
- Two frames back-to-back (0x11, 0x22) with a single stop bit -> two data_valid pulses, 80 cycles apart at P = 8, no par_en.
